// File: rtl/sample_to_double_sched.sv
// sample_to_double_sched: round-robin shared 16-bit signed sample to IEEE-754 double normalizer.
module sample_to_double_sched #(
  parameter logic FAST_SHIFT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] sample_a,
  input  logic        req_b,
  input  logic [15:0] sample_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        busy,
  output logic [63:0] double_out,
  output logic        ch_out,
  output logic        valid_out
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t      r_state, w_state_n;
  logic        r_last, w_last_n;
  logic        r_sign, w_sign_n;
  logic [15:0] r_mag, w_mag_n;
  logic [3:0]  r_exp, w_exp_n;
  logic        r_ch, w_ch_n;
  logic        r_zero, w_zero_n;
  logic        r_gnt_a, w_gnt_a_n;
  logic        r_gnt_b, w_gnt_b_n;
  logic        r_valid, w_valid_n;
  logic        r_ch_out, w_ch_out_n;
  logic [63:0] r_dout, w_dout_n;
  logic        w_pick_b;
  logic [15:0] w_smp;
  logic [15:0] w_abs;
  logic        w_fast;
  // r_last = 1 means B was granted last, so A wins the next tie
  assign w_pick_b = req_b & (~req_a | ~r_last);
  assign w_smp    = w_pick_b ? sample_b : sample_a;
  assign w_abs    = w_smp[15] ? ~w_smp + 16'd1 : w_smp;
  assign w_fast   = FAST_SHIFT && (r_mag[15:12] == 4'd0);
  always_comb begin
    w_state_n  = r_state;
    w_last_n   = r_last;
    w_sign_n   = r_sign;
    w_mag_n    = r_mag;
    w_exp_n    = r_exp;
    w_ch_n     = r_ch;
    w_zero_n   = r_zero;
    w_gnt_a_n  = 1'b0;
    w_gnt_b_n  = 1'b0;
    w_valid_n  = 1'b0;
    w_ch_out_n = r_ch_out;
    w_dout_n   = r_dout;
    case (r_state)
      IDLE: if (req_a | req_b) begin
        w_state_n = (w_abs == 16'd0) ? DONE : NORM;
        w_sign_n  = w_smp[15];
        w_mag_n   = w_abs;
        w_exp_n   = 4'd15;
        w_ch_n    = w_pick_b;
        w_last_n  = w_pick_b;
        w_zero_n  = (w_abs == 16'd0);
        w_gnt_a_n = ~w_pick_b;
        w_gnt_b_n = w_pick_b;
      end
      NORM: if (r_mag[15]) w_state_n = DONE;
      else begin
        w_mag_n = w_fast ? r_mag << 4 : r_mag << 1;
        w_exp_n = r_exp - (w_fast ? 4'd4 : 4'd1);
      end
      DONE: begin
        w_state_n  = IDLE;
        w_valid_n  = 1'b1;
        w_ch_out_n = r_ch;
        w_dout_n   = r_zero ? 64'd0 : {r_sign, 11'(11'd1023 + {7'd0, r_exp}), r_mag[14:0], 37'd0};
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_sign   <= 1'b0;
      r_mag    <= 16'd0;
      r_exp    <= 4'd0;
      r_ch     <= 1'b0;
      r_zero   <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_valid  <= 1'b0;
      r_ch_out <= 1'b0;
      r_dout   <= 64'd0;
    end else begin
      r_state  <= w_state_n;
      r_last   <= w_last_n;
      r_sign   <= w_sign_n;
      r_mag    <= w_mag_n;
      r_exp    <= w_exp_n;
      r_ch     <= w_ch_n;
      r_zero   <= w_zero_n;
      r_gnt_a  <= w_gnt_a_n;
      r_gnt_b  <= w_gnt_b_n;
      r_valid  <= w_valid_n;
      r_ch_out <= w_ch_out_n;
      r_dout   <= w_dout_n;
    end
  end
  assign gnt_a      = r_gnt_a;
  assign gnt_b      = r_gnt_b;
  assign busy       = (r_state != IDLE);
  assign double_out = r_dout;
  assign ch_out     = r_ch_out;
  assign valid_out  = r_valid;
endmodule

// File: tb/tb_sample_to_double_sched.sv
// tb_sample_to_double_sched: directed checks of arbitration, latency and double encoding.
module tb_sample_to_double_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0, req_a0 = 1'b0, req_b0 = 1'b0;
  logic [15:0] sample_a = 16'd0, sample_b = 16'd0, sample_a0 = 16'd0, sample_b0 = 16'd0;
  logic        gnt_a, gnt_b, busy, ch_out, valid_out;
  logic        gnt_a0, gnt_b0, busy0, ch0, valid0;
  logic [63:0] double_out, dout0;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  sample_to_double_sched #(.FAST_SHIFT(1'b1)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .sample_a(sample_a), .req_b(req_b), .sample_b(sample_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .double_out(double_out), .ch_out(ch_out), .valid_out(valid_out)
  );
  sample_to_double_sched #(.FAST_SHIFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_a(req_a0), .sample_a(sample_a0), .req_b(req_b0), .sample_b(sample_b0),
    .gnt_a(gnt_a0), .gnt_b(gnt_b0), .busy(busy0), .double_out(dout0), .ch_out(ch0), .valid_out(valid0)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic cur_gnt(input bit slow, input bit ch);
    return slow ? gnt_a0 : (ch ? gnt_b : gnt_a);
  endfunction
  task automatic conv(input bit slow, input bit ch, input logic [15:0] s, input int lat,
                      input logic [63:0] exp, input string tag);
    int e;
    int ng;
    bit busy_ok;
    if (slow) begin req_a0 = 1'b1; sample_a0 = s; end
    else if (ch) begin req_b = 1'b1; sample_b = s; end
    else begin req_a = 1'b1; sample_a = s; end
    e = 0;
    do begin @(negedge clk); e++; end while (!cur_gnt(slow, ch) && e < 60);
    chk({tag, "_gnt"}, 64'(cur_gnt(slow, ch)), 64'd1);
    if (slow) req_a0 = 1'b0; else if (ch) req_b = 1'b0; else req_a = 1'b0;
    e = 0;
    ng = 1;
    busy_ok = 1'b1;
    while (!(slow ? valid0 : valid_out) && e < 60) begin
      if (!(slow ? busy0 : busy)) busy_ok = 1'b0;
      @(negedge clk);
      e++;
      if (cur_gnt(slow, ch)) ng++;
    end
    chk({tag, "_valid"}, 64'(slow ? valid0 : valid_out), 64'd1);
    if (lat >= 0) chk({tag, "_lat"}, 64'(e), 64'(lat));
    chk({tag, "_dout"}, slow ? dout0 : double_out, exp);
    chk({tag, "_ch"}, 64'(slow ? ch0 : ch_out), 64'(ch));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    repeat (2) begin @(negedge clk); if (cur_gnt(slow, ch)) ng++; end
    chk({tag, "_ngnt"}, 64'(ng), 64'd1);
  endtask
  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int g;
    int v;
    bit pv;
    bit vseen;
    logic [15:0] s;
    bit c;
    repeat (3) @(negedge clk);
    chk("rst_dout", double_out, 64'd0);
    chk("rst_flags", 64'({gnt_a, gnt_b, valid_out, busy, ch_out}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    conv(0, 0, 16'd1,     8,  64'h3FF0000000000000, "a_p1");
    conv(0, 0, 16'hFFFF,  8,  64'hBFF0000000000000, "a_m1");
    conv(0, 0, 16'd12345, -1, 64'h40C81C8000000000, "a_12345");
    conv(0, 0, 16'h8000,  2,  64'hC0E0000000000000, "a_min");
    conv(0, 1, 16'd0,     1,  64'h0000000000000000, "b_zero");
    conv(1, 0, 16'd1,     17, 64'h3FF0000000000000, "slow_p1");
    // both channels held: grants alternate and each capture lands in the previous valid cycle
    req_a = 1'b1; sample_a = 16'd16384;
    req_b = 1'b1; sample_b = 16'hFFFE;
    g = 0; v = 0; pv = 1'b0;
    for (int i = 0; i < 200 && v < 4; i++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) begin
        chk("rr_order", 64'(gnt_b), 64'(g % 2));
        if (g > 0) chk("rr_b2b", 64'(pv), 64'd1);
        g++;
        if (g == 4) begin req_a = 1'b0; req_b = 1'b0; end
      end
      if (valid_out) begin
        chk("rr_ch", 64'(ch_out), 64'(v % 2));
        chk("rr_dout", double_out, (v % 2) ? 64'hC000000000000000 : 64'h40D0000000000000);
        v++;
      end
      pv = valid_out;
    end
    chk("rr_count", 64'(v), 64'd4);
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clk);
    // reset during NORM with B waiting
    req_a = 1'b1; sample_a = 16'd1;
    g = 0;
    while (!gnt_a && g < 20) begin @(negedge clk); g++; end
    chk("mid_gnt_a", 64'(gnt_a), 64'd1);
    req_a = 1'b0;
    req_b = 1'b1; sample_b = 16'hFFFE;
    vseen = 1'b0;
    @(negedge clk);
    vseen |= valid_out;
    rst = 1'b1;
    @(negedge clk);
    vseen |= valid_out;
    chk("mid_novalid", 64'(vseen), 64'd0);
    chk("mid_dout", double_out, 64'd0);
    chk("mid_flags", 64'({gnt_a, gnt_b, valid_out, busy, ch_out}), 64'd0);
    rst = 1'b0;
    conv(0, 1, 16'hFFFE, 7, 64'hC000000000000000, "mid_b");
    for (int i = 0; i < 200; i++) begin
      s = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      conv(0, c, s, -1, $realtobits(real'($signed(s))), "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
